// File: rtl/lfsr_stream_checker_pkg.sv
// Shared constants for the LFSR stream checker: generator taps, FSM encoding, default width.
package lfsr_stream_checker_pkg;

    localparam int DEFAULT_W = 16;

    // Must stay identical to the generator's taps or the checker never locks.
    localparam int TAP0 = 0;
    localparam int TAP1 = 2;
    localparam int TAP2 = 3;
    localparam int TAP3 = 5;

    localparam logic [1:0] SEED   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

endpackage

// File: rtl/lfsr_stream_checker_predictor.sv
// Local copy of the generator register: fills from the received stream or free-runs
// on its own feedback, and exposes the predicted next bit.
module lfsr_predictor
    import lfsr_stream_checker_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load_ext,
    input  logic ext_bit,
    output logic pred,
    output logic next_zero
);

    logic [W-1:0] s_q, s_d;

    assign pred = s_q[TAP0] ^ s_q[TAP1] ^ s_q[TAP2] ^ s_q[TAP3];

    // In feedback mode the received bit is ignored so line errors never reach the register.
    always_comb begin
        s_d = s_q;
        if (en) begin
            s_d = {(load_ext ? ext_bit : pred), s_q[W-1:1]};
        end
    end

    assign next_zero = (s_d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 16-bit LFSR test stream: self-synchronises, flags
// bit errors and counts errors/bits while locked.
module lfsr_stream_checker
    import lfsr_stream_checker_pkg::*;
#(
    parameter int W          = DEFAULT_W,
    parameter int LOCK_COUNT = 32,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W  = $clog2(W + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W   = $clog2(LOSS_COUNT + 1);

    logic [1:0]         state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               bit_err_q, bit_err_d;

    logic pred, next_zero, mismatch;

    lfsr_predictor #(.W(W)) u_pred (
        .clk       (clk),
        .reset     (reset),
        .en        (in_valid),
        .load_ext  (state_q == SEED),
        .ext_bit   (in_bit),
        .pred      (pred),
        .next_zero (next_zero)
    );

    assign mismatch = in_bit ^ pred;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        match_d   = match_q;
        run_d     = run_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        bit_err_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEED: begin
                    if (fill_q == FILL_W'(W - 1)) begin
                        fill_d = '0;
                        // An all-zero fill is the LFSR lock-up state; keep seeding.
                        if (!next_zero) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        state_d   = SEED;
                        fill_d    = '0;
                    end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        run_d   = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 1'b1;
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                        if (run_q == RUN_W'(LOSS_COUNT - 1)) begin
                            state_d = SEED;
                            fill_d  = '0;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                end
            endcase
        end
        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SEED;
            fill_q    <= '0;
            match_q   <= '0;
            run_q     <= '0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            run_q     <= run_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bit_err_q <= bit_err_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign bit_err   = bit_err_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scenario bench for lfsr_stream_checker: a reference generator drives the stream and a
// queue of expected bit_err values is checked one cycle after each driven bit.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] gen_s;
    logic        exp_q[$];

    always #5 clk = ~clk;

    lfsr_stream_checker dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    task automatic gen_bit(output logic b);
        b = gen_s[0] ^ gen_s[2] ^ gen_s[3] ^ gen_s[5];
        gen_s = {b, gen_s[15:1]};
    endtask

    // Drive one cycle; the expected bit_err for it is queued now and popped after the edge.
    task automatic send(input logic v, input logic b, input logic exp_err, input logic clr);
        logic e;
        in_valid = v;
        in_bit   = b;
        clear    = clr;
        exp_q.push_back(v ? exp_err : 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (bit_err !== e) begin
            n_bad++;
            $display("FAIL bit_err: got %b want %b at %0t", bit_err, e, $time);
        end
    endtask

    task automatic clean_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lock_point(input string name);
        clean_bits(47);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL %s_early: locked=%b want 0", name, locked); end
        clean_bits(1);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL %s_lock: locked=%b want 1", name, locked); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({locked, bit_err} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: locked=%b bit_err=%b want 0 0", locked, bit_err);
        end
        n_cmp++;
        if ({err_count, bit_count} !== 32'd0) begin
            n_bad++; $display("FAIL reset_counts: err=%0d bits=%0d want 0 0", err_count, bit_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        gen_s = 16'hACE1;
        check_lock_point("ace1");
        n_cmp++;
        if (err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_bad++; $display("FAIL lock_counts: err=%0d bits=%0d want 0 0", err_count, bit_count);
        end
    endtask

    task automatic test_single_err();
        logic b;
        clean_bits(10);
        n_cmp++;
        if (bit_count !== 16'd10) begin n_bad++; $display("FAIL single_bits0: got %0d want 10", bit_count); end
        gen_bit(b);
        send(1'b1, ~b, 1'b1, 1'b0);
        n_cmp++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL single_err: err=%0d locked=%b want 1 1", err_count, locked);
        end
        clean_bits(5);
        n_cmp++;
        if (err_count !== 16'd1 || bit_count !== 16'd16 || locked !== 1'b1) begin
            n_bad++; $display("FAIL single_after: err=%0d bits=%0d locked=%b want 1 16 1", err_count, bit_count, locked);
        end
    endtask

    task automatic test_burst();
        logic b;
        gen_bit(b);
        send(1'b1, b, 1'b0, 1'b1);
        n_cmp++;
        if (err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_bad++; $display("FAIL burst_clear: err=%0d bits=%0d want 0 0", err_count, bit_count);
        end
        for (int i = 0; i < 3; i++) begin
            gen_bit(b);
            send(1'b1, ~b, 1'b1, 1'b0);
            n_cmp++;
            if (locked !== 1'b1) begin n_bad++; $display("FAIL burst_hold%0d: locked=%b want 1", i, locked); end
        end
        gen_bit(b);
        send(1'b1, ~b, 1'b1, 1'b0);
        n_cmp++;
        if (locked !== 1'b0 || err_count !== 16'd4 || bit_count !== 16'd4) begin
            n_bad++; $display("FAIL burst_loss: locked=%b err=%0d bits=%0d want 0 4 4", locked, err_count, bit_count);
        end
        check_lock_point("relock");
        n_cmp++;
        if (err_count !== 16'd4 || bit_count !== 16'd4) begin
            n_bad++; $display("FAIL burst_hold_counts: err=%0d bits=%0d want 4 4", err_count, bit_count);
        end
    endtask

    task automatic test_seed_zeros();
        do_reset();
        for (int i = 0; i < 48; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL zeros_lock: locked=%b want 0", locked); end
        check_lock_point("zeros");
    endtask

    task automatic test_random_valid();
        logic b;
        int   vcount = 0;
        do_reset();
        gen_s = 16'hACE1;
        for (int guard = 0; guard < 2000 && vcount < 48; guard++) begin
            if ($urandom_range(1) == 1) begin
                gen_bit(b);
                send(1'b1, b, 1'b0, 1'b0);
                vcount++;
                if (vcount == 47) begin
                    n_cmp++;
                    if (locked !== 1'b0) begin n_bad++; $display("FAIL rnd_early: locked=%b want 0", locked); end
                end
            end else begin
                send(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
            end
        end
        n_cmp++;
        if (vcount != 48 || locked !== 1'b1 || err_count !== 16'd0) begin
            n_bad++; $display("FAIL rnd_lock: vbits=%0d locked=%b err=%0d want 48 1 0", vcount, locked, err_count);
        end
        send(1'b0, 1'b1, 1'b0, 1'b0);
        gen_bit(b);
        send(1'b1, ~b, 1'b1, 1'b1);
        n_cmp++;
        if (err_count !== 16'd0 || bit_count !== 16'd0 || locked !== 1'b1) begin
            n_bad++; $display("FAIL clear_wins: err=%0d bits=%0d locked=%b want 0 0 1", err_count, bit_count, locked);
        end
    endtask

    task automatic test_reset_mid();
        clean_bits(5);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_bad++; $display("FAIL async_reset: locked=%b err=%0d bits=%0d want 0 0 0", locked, err_count, bit_count);
        end
        @(negedge clk);
        reset = 1'b1;
        check_lock_point("post_reset");
        n_cmp++;
        if (err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_bad++; $display("FAIL post_reset_counts: err=%0d bits=%0d want 0 0", err_count, bit_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_burst();
        test_seed_zeros();
        test_random_valid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
